// File: rtl/calc_op_sequencer.sv
// Operation sequencer for an external 8-bit ALU: accepts one instruction at a time,
// waits the ALU latency, captures the result and holds it until the consumer takes it.
module calc_op_sequencer #(
   parameter int MUL_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [17:0] req_instr,
   input  logic        req_use_acc,
   output logic [17:0] alu_instr,
   input  logic [7:0]  alu_out,
   input  logic [7:0]  alu_ext_out,
   input  logic        alu_carry,
   input  logic        alu_overflow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic        rsp_carry,
   output logic        rsp_overflow,
   output logic [7:0]  acc,
   output logic [7:0]  op_count,
   output logic        busy
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
   // req_ready is high only in IDLE, rsp_valid is high only in DONE.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] MUL_WAIT = 4'(MUL_LATENCY);
   localparam logic [1:0] OP_MUL   = 2'b11;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] wait_cnt;
   logic       accept;
   logic       capture;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid)         state_d = EXEC;
         EXEC:    if (wait_cnt == 4'd1)  state_d = DONE;
         DONE:    if (rsp_ready)         state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            accept    = req_valid;
         end
         EXEC: begin
            capture = (wait_cnt == 4'd1);
         end
         DONE: begin
            rsp_valid = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Datapath: instruction register, wait counter, result capture, accumulator
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_instr    <= '0;
         wait_cnt     <= '0;
         rsp_result   <= '0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         acc          <= '0;
         op_count     <= '0;
      end else begin
         if (accept) begin
            alu_instr <= req_use_acc ? {req_instr[17:16], acc, req_instr[7:0]} : req_instr;
            wait_cnt  <= (req_instr[17:16] == OP_MUL) ? MUL_WAIT : 4'd1;
         end else if (state_q == EXEC) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (capture) begin
            rsp_result   <= {alu_ext_out, alu_out};
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            acc          <= alu_out;
            op_count     <= op_count + 8'd1;
         end
      end
   end

endmodule
